// File: rtl/vfpu_fma_arb.sv
// vfpu_fma_arb: round-robin issue arbiter sharing one in-order FMA datapath across NUM_REQ lanes.
// Define VFPU_FMA_ARB_PERF_EN to add saturating issue and special-result counters.
module vfpu_fma_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MAX_OUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_op_a,
    input  logic [32*NUM_REQ-1:0]  req_op_b,
    input  logic [32*NUM_REQ-1:0]  req_op_c,
    input  logic [NUM_REQ-1:0]     req_nj_mode,
    input  logic [NUM_REQ-1:0]     req_inv_mask,
    output logic                   fma_valid,
    output logic [31:0]            fma_op_a,
    output logic [31:0]            fma_op_b,
    output logic [31:0]            fma_op_c,
    output logic                   fma_nj_mode,
    output logic                   fma_inv_mask,
    input  logic                   fma_res_valid,
    input  logic [31:0]            fma_res,
    input  logic                   fma_spec_mask,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   rsp_spec,
    output logic                   err_tag
`ifdef VFPU_FMA_ARB_PERF_EN
    ,
    output logic [15:0]            perf_issue_cnt,
    output logic [15:0]            perf_spec_cnt
`endif
);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  rr_ptr, win, idx;
    logic             found, accept, pop;
    logic [CNT_W-1:0] count, credits;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [ID_W-1:0]  tags [MAX_OUT];

    // Credits mirror free tag slots, so the FIFO can never overflow.
    assign credits = CNT_W'(MAX_OUT) - count;
    assign pop     = fma_res_valid && count != '0;
    assign accept  = found && (credits != '0 || fma_res_valid);
    assign req_ready = accept ? NUM_REQ'(1) << win : '0;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tags[wr_ptr] <= win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fma_valid    <= 1'b0;
            fma_op_a     <= '0;
            fma_op_b     <= '0;
            fma_op_c     <= '0;
            fma_nj_mode  <= 1'b0;
            fma_inv_mask <= 1'b0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_spec     <= 1'b0;
            err_tag      <= 1'b0;
        end else begin
            fma_valid <= accept;
            rsp_valid <= pop ? NUM_REQ'(1) << tags[rd_ptr] : '0;
            if (accept) begin
                fma_op_a     <= req_op_a[32*int'(win) +: 32];
                fma_op_b     <= req_op_b[32*int'(win) +: 32];
                fma_op_c     <= req_op_c[32*int'(win) +: 32];
                fma_nj_mode  <= req_nj_mode[win];
                fma_inv_mask <= req_inv_mask[win];
                rr_ptr       <= win == ID_W'(NUM_REQ - 1) ? '0 : win + ID_W'(1);
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                rsp_data <= fma_res;
                rsp_spec <= fma_spec_mask;
            end
            if (accept != pop) count <= accept ? count + CNT_W'(1) : count - CNT_W'(1);
            if (fma_res_valid && count == '0) err_tag <= 1'b1;
        end
    end

`ifdef VFPU_FMA_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_spec_cnt  <= '0;
        end else begin
            if (accept && perf_issue_cnt != 16'hFFFF) perf_issue_cnt <= perf_issue_cnt + 16'd1;
            if (|rsp_valid && rsp_spec && perf_spec_cnt != 16'hFFFF) perf_spec_cnt <= perf_spec_cnt + 16'd1;
        end
    end
`endif
endmodule
